// File: rtl/apb_manager_ctrl.sv
// APB manager: accepts one request at a time, decodes it onto a peripheral
// select lane, runs the SETUP/ACCESS phases with a wait timeout and holds the response.
module apb_manager_ctrl #(
    parameter int AddrWidth     = 32,
    parameter int DataWidth     = 32,
    parameter int PrphNum       = 4,
    parameter int RegionBits    = 12,
    parameter int TimeoutCycles = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   reqValid,
    output logic                   reqReady,
    input  logic [AddrWidth-1:0]   reqAddr,
    input  logic                   reqWrite,
    input  logic [DataWidth-1:0]   reqWData,
    input  logic [DataWidth/8-1:0] reqStrb,
    input  logic [3:0]             reqProt,
    output logic                   rspValid,
    input  logic                   rspReady,
    output logic [DataWidth-1:0]   rspRData,
    output logic                   rspError,
    output logic [AddrWidth-1:0]   addr,
    output logic [3:0]             prot,
    output logic [PrphNum-1:0]     selectors,
    output logic                   enable,
    output logic                   write,
    output logic [DataWidth-1:0]   wData,
    output logic [DataWidth/8-1:0] strb,
    input  logic                   ready,
    input  logic [DataWidth-1:0]   rData,
    input  logic                   subError
);

    localparam int StrbWidth = DataWidth / 8;
    localparam int CntWidth  = $clog2(TimeoutCycles + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_e;

    state_e                 state_q, state_d;
    logic [AddrWidth-1:0]   addr_q, addr_d;
    logic [3:0]             prot_q, prot_d;
    logic                   write_q, write_d;
    logic [DataWidth-1:0]   wdata_q, wdata_d;
    logic [StrbWidth-1:0]   strb_q, strb_d;
    logic [PrphNum-1:0]     sel_q, sel_d;
    logic [CntWidth-1:0]    cnt_q, cnt_d;
    logic [DataWidth-1:0]   rdata_q, rdata_d;
    logic                   err_q, err_d;

    logic [AddrWidth-1:0]   dec_idx;
    logic                   dec_hit;
    logic [PrphNum-1:0]     dec_onehot;

    assign dec_idx = reqAddr >> RegionBits;
    assign dec_hit = (dec_idx < AddrWidth'(PrphNum));

    always_comb begin
        dec_onehot = '0;
        for (int i = 0; i < PrphNum; i++) begin
            dec_onehot[i] = (dec_idx == AddrWidth'(i));
        end
    end

    always_comb begin
        // NOTE: every next-state value defaults to its register first, so no path can infer a latch.
        state_d = state_q;
        addr_d  = addr_q;
        prot_d  = prot_q;
        write_d = write_q;
        wdata_d = wdata_q;
        strb_d  = strb_q;
        sel_d   = sel_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        err_d   = err_q;

        unique case (state_q)
            IDLE: begin
                if (reqValid) begin
                    addr_d  = reqAddr;
                    prot_d  = reqProt;
                    write_d = reqWrite;
                    wdata_d = reqWData;
                    strb_d  = reqWrite ? reqStrb : '0;
                    if (dec_hit) begin
                        sel_d   = dec_onehot;
                        state_d = SETUP;
                    end else begin
                        // Unmapped address: answer with an error without touching the bus.
                        sel_d   = '0;
                        rdata_d = '0;
                        err_d   = 1'b1;
                        state_d = RESP;
                    end
                end
            end
            SETUP: begin
                cnt_d   = '0;
                state_d = ACCESS;
            end
            ACCESS: begin
                if (ready) begin
                    rdata_d = write_q ? '0 : rData;
                    err_d   = subError;
                    sel_d   = '0;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + CntWidth'(1);
                    if (cnt_q == CntWidth'(TimeoutCycles - 1)) begin
                        rdata_d = '0;
                        err_d   = 1'b1;
                        sel_d   = '0;
                        state_d = RESP;
                    end
                end
            end
            RESP: begin
                if (rspReady) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            prot_q  <= '0;
            write_q <= 1'b0;
            wdata_q <= '0;
            strb_q  <= '0;
            sel_q   <= '0;
            cnt_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            prot_q  <= prot_d;
            write_q <= write_d;
            wdata_q <= wdata_d;
            strb_q  <= strb_d;
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Bus controls derive from the state, so reset clears them without waiting for a clock.
    assign reqReady  = (state_q == IDLE) && !reset;
    assign rspValid  = (state_q == RESP);
    assign rspRData  = rdata_q;
    assign rspError  = err_q;
    assign addr      = addr_q;
    assign prot      = prot_q;
    assign write     = write_q;
    assign wData     = wdata_q;
    assign strb      = strb_q;
    assign selectors = ((state_q == SETUP) || (state_q == ACCESS)) ? sel_q : '0;
    assign enable    = (state_q == ACCESS);

endmodule

// File: doc/apb_manager_ctrl.md
APB_MANAGER_CTRL -- requirements
Module: apb_manager_ctrl

Interface
REQ-001 The block SHALL have parameter AddrWidth, default 32, meaning the APB byte address width.
REQ-002 The block SHALL have parameter DataWidth, default 32, meaning the data width; it must be a multiple of 8.
REQ-003 The block SHALL have parameter PrphNum, default 4, meaning the number of peripherals, one select lane each.
REQ-004 The block SHALL have parameter RegionBits, default 12, meaning the log2 of the byte window size per peripheral.
REQ-005 The block SHALL have parameter TimeoutCycles, default 16, meaning the maximum number of ACCESS cycles before abort; it must be at least 1.
REQ-006 The block SHALL have one clock and an asynchronous, active-high reset, with ports as follows.
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- reqValid  in  1  request offered
- reqReady  out  1  request accepted this cycle
- reqAddr  in  AddrWidth  request byte address
- reqWrite  in  1  1 = write, 0 = read
- reqWData  in  DataWidth  write data
- reqStrb  in  DataWidth/8  write byte strobes
- reqProt  in  4  protection attributes
- rspValid  out  1  response available
- rspReady  in  1  response consumed
- rspRData  out  DataWidth  read data
- rspError  out  1  transfer error
- addr  out  AddrWidth  APB address
- prot  out  4  APB protection
- selectors  out  PrphNum  one-hot peripheral select
- enable  out  1  APB access phase
- write  out  1  APB direction
- wData  out  DataWidth  APB write data
- strb  out  DataWidth/8  APB strobes
- ready  in  1  muxed peripheral ready
- rData  in  DataWidth  muxed peripheral read data
- subError  in  1  muxed peripheral error

Function
REQ-007 The FSM SHALL have the states IDLE, SETUP, ACCESS and RESP.
REQ-008 reqReady SHALL be 1 exactly when the state is IDLE; a handshake occurs when reqValid and reqReady are both 1 on a clk edge.
REQ-009 On handshake, the block SHALL register addr, prot, write and wData, and SHALL register strb as reqStrb for writes and as all-zero for reads.
REQ-010 The decode index SHALL be reqAddr >> RegionBits; if the index is below PrphNum, the next state SHALL be SETUP; otherwise the next state SHALL be RESP with rspError=1 and rspRData=0, and no APB cycle SHALL occur.
REQ-011 In SETUP, selectors SHALL be one-hot at the decode index and enable SHALL be 0; the state SHALL last exactly one cycle, then go to ACCESS.
REQ-012 In ACCESS, selectors SHALL be held and enable SHALL be 1; addr, prot, write, wData and strb SHALL remain stable from SETUP until leaving ACCESS.
REQ-013 In ACCESS with ready=1, the block SHALL capture rspRData = rData for reads and 0 for writes, SHALL capture rspError = subError, SHALL clear selectors and enable, and SHALL go to RESP.
REQ-014 A wait counter SHALL clear on entry to ACCESS and increment on each ACCESS cycle with ready=0.
- When it reaches TimeoutCycles with ready still 0, the block SHALL go to RESP with rspError=1 and rspRData=0, and clear selectors and enable.
- ready=1 on the same cycle as the limit SHALL take precedence as a normal completion.
REQ-015 In RESP, rspValid SHALL be 1; rspRData and rspError SHALL be held until a cycle with rspReady=1, after which the state SHALL be IDLE and rspValid SHALL be 0.
REQ-016 Minimum latency SHALL be: handshake at edge N, SETUP in cycle N+1, ACCESS in cycle N+2 with ready=1, rspValid in cycle N+3, next reqReady in cycle N+4 if rspReady was 1 in cycle N+3.
REQ-017 When the state is not IDLE, the block SHALL ignore reqValid and SHALL accept only one outstanding request.
REQ-018 selectors SHALL never have more than one bit set, and enable SHALL be 1 only when selectors is non-zero.
REQ-019 ready, rData and subError SHALL be ignored outside ACCESS.

Reset
REQ-020 While reset=1, the block SHALL asynchronously force state IDLE and SHALL drive all outputs and registers to 0, including selectors=0, enable=0, rspValid=0 and the wait counter.
REQ-021 Reset asserted mid-transfer in SETUP, ACCESS or RESP SHALL abort the transfer, produce no response, and leave reqReady=1 on the first cycle after reset deasserts.

Verification
REQ-022 Zero-wait read (defaults): reqAddr=0x1004, ready=1 in ACCESS, rData=0xDEADBEEF -> selectors=4'b0010 in SETUP and ACCESS, enable 0 then 1, rspValid in cycle N+3 with rspRData=0xDEADBEEF and rspError=0.
REQ-023 Write with 3 wait states: reqAddr=0x3000, reqWData=0xA5A5A5A5, reqStrb=4'b0101, ready low for 3 ACCESS cycles -> selectors=4'b1000, strb=4'b0101 stable throughout, rspRData=0 and rspError=0.
REQ-024 Decode error: reqAddr=0x4000 -> selectors never asserted, rspValid=1 in cycle N+1 with rspError=1 and rspRData=0.
REQ-025 Timeout: ready held 0 -> exactly 16 ACCESS cycles, then rspError=1; also ready=1 on the 16th ACCESS cycle -> normal completion with rspError=subError.
REQ-026 Backpressure plus reset: rspReady held 0 for 5 cycles -> response held stable and reqReady=0; then assert reset in ACCESS -> selectors=0, enable=0 and rspValid=0 immediately, and reqReady=1 after release.
